// File: rtl/disp_scan_sched_pkg.sv
// Shared constants, state encoding and frame payload for the display scan scheduler.
package disp_scan_sched_pkg;

  localparam int unsigned NUM_DIGITS    = 6;
  localparam int unsigned NUM_SEGS      = 7;
  localparam int unsigned GAP_TICKS_DEF = 1;
  localparam int unsigned DIG_W         = 4;
  localparam int unsigned BCD_W         = NUM_DIGITS * DIG_W;
  localparam int unsigned DISP_W        = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W         = $clog2(NUM_SEGS);

  localparam logic [DIG_W-1:0] BLANK_CODE = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][DIG_W-1:0] bcd;
    logic [NUM_DIGITS-1:0]            blank_mask;
    logic                             lz_en;
  } frame_t;

  // Digit is dark when masked, non-BCD, or a suppressed leading zero on the top digit.
  function automatic logic digit_blanked(input frame_t f, input logic [DISP_W-1:0] idx);
    logic [DIG_W-1:0] d;
    d = f.bcd[idx];
    return f.blank_mask[idx] || (d > 4'd9) ||
           (f.lz_en && (idx == DISP_W'(NUM_DIGITS - 1)) && (d == '0));
  endfunction

endpackage

// File: rtl/disp_frame_buf.sv
// Pending/active frame double buffer with valid/ready intake and boundary load.
module disp_frame_buf
  import disp_scan_sched_pkg::*;
(
  input  logic   clk_500u,
  input  logic   rst,
  input  logic   frame_valid_i,
  output logic   frame_ready_o,
  input  frame_t frame_i,
  input  logic   load_i,
  output frame_t pend_o,
  output frame_t act_o,
  output logic   pend_full_o
);

  frame_t pend_q, pend_d;
  frame_t act_q, act_d;
  logic   full_q, full_d;

  // Load at boundary frees the pending slot; intake only when the slot is empty.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    full_d = full_q;
    if (load_i && full_q) begin
      act_d  = pend_q;
      full_d = 1'b0;
    end
    if (frame_valid_i && !full_q) begin
      pend_d = frame_i;
      full_d = 1'b1;
    end
  end

  // Buffer registers; reset drops both frames.
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      act_q  <= '0;
      full_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      full_q <= full_d;
    end
  end

  assign frame_ready_o = ~full_q;
  assign pend_o        = pend_q;
  assign act_o         = act_q;
  assign pend_full_o   = full_q;

endmodule

// File: rtl/disp_scan_sched.sv
// Segment/digit scan scheduler for the 6-digit serial 7-segment display.
module disp_scan_sched
  import disp_scan_sched_pkg::*;
#(
  parameter int unsigned GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic                  clk_500u,
  input  logic                  rst,
  input  logic                  frame_valid_i,
  output logic                  frame_ready_o,
  input  logic [BCD_W-1:0]      frame_bcd_i,
  input  logic [NUM_DIGITS-1:0] blank_mask_i,
  input  logic                  lz_en_i,
  input  logic                  disp_type_i,
  input  logic [NUM_SEGS-1:0]   seg_vec_i,
  output logic [DIG_W-1:0]      bcd_out_o,
  output logic [DISP_W-1:0]     disp_sel_o,
  output logic [SEG_W-1:0]      seg_sel_o,
  output logic                  seg_bit_o,
  output logic                  blank_o,
  output logic                  frame_start_o
);

  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST   = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;
  localparam logic [DISP_W-1:0] LAST_DIGIT = DISP_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]  LAST_SEG   = SEG_W'(NUM_SEGS - 1);

  scan_state_e       state_q, state_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DIG_W-1:0]  bcd_q, bcd_d;
  logic              blank_q, blank_d;
  logic              fs_q, fs_d;

  logic   load_c;
  logic   next_digit_c;
  frame_t frame_in_c;
  frame_t view_c;
  frame_t pend_frame;
  frame_t act_frame;
  logic   pend_full;

  // Pack the incoming frame fields into the buffer payload.
  always_comb begin
    frame_in_c.bcd        = frame_bcd_i;
    frame_in_c.blank_mask = blank_mask_i;
    frame_in_c.lz_en      = lz_en_i;
  end

  disp_frame_buf u_frame_buf (
    .clk_500u      (clk_500u),
    .rst           (rst),
    .frame_valid_i (frame_valid_i),
    .frame_ready_o (frame_ready_o),
    .frame_i       (frame_in_c),
    .load_i        (load_c),
    .pend_o        (pend_frame),
    .act_o         (act_frame),
    .pend_full_o   (pend_full)
  );

  // Scan sequencing plus next-tick output decode from the frame that will be active.
  always_comb begin
    state_d      = state_q;
    disp_d       = disp_q;
    seg_d        = seg_q;
    gap_d        = gap_q;
    load_c       = 1'b0;
    next_digit_c = 1'b0;
    bcd_d        = BLANK_CODE;
    blank_d      = 1'b1;
    fs_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_full) begin
          state_d = ST_SCAN;
          disp_d  = '0;
          seg_d   = '0;
          load_c  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (seg_q == LAST_SEG) begin
          seg_d = '0;
          if (GAP_TICKS > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            next_digit_c = 1'b1;
          end
        end else begin
          seg_d = seg_q + SEG_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d      = ST_SCAN;
          gap_d        = '0;
          next_digit_c = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wrapping past the last digit is the frame boundary.
    if (next_digit_c) begin
      if (disp_q == LAST_DIGIT) begin
        disp_d = '0;
        load_c = 1'b1;
      end else begin
        disp_d = disp_q + DISP_W'(1);
      end
    end

    view_c = (load_c && pend_full) ? pend_frame : act_frame;

    if (state_d == ST_SCAN) begin
      fs_d = (disp_d == '0) && (seg_d == '0);
      if (!digit_blanked(view_c, disp_d)) begin
        blank_d = 1'b0;
        bcd_d   = view_c.bcd[disp_d];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      disp_q  <= '0;
      seg_q   <= '0;
      gap_q   <= '0;
      bcd_q   <= BLANK_CODE;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      gap_q   <= gap_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign bcd_out_o     = bcd_q;
  assign disp_sel_o    = disp_q;
  assign seg_sel_o     = seg_q;
  assign blank_o       = blank_q;
  assign frame_start_o = fs_q;

  // Off level equals disp_type; lit ticks pass the decoder bit straight through.
  assign seg_bit_o = blank_q ? disp_type_i : seg_vec_i[seg_sel_q_idx()];

  function automatic logic [SEG_W-1:0] seg_sel_q_idx();
    return seg_q;
  endfunction

endmodule
